// File: rtl/gestor_solicitudes_n.sv
// Elevator request manager: cabin/hall bitmaps, collective-SCAN direction FSM.
// Optional: `define CABIN_CANCEL_EN makes a repeated cabin call cancel it.
module gestor_solicitudes_n #(
  parameter  int N_FLOORS = 4,
  localparam int FW = $clog2(N_FLOORS),
  localparam int CW = $clog2(3*N_FLOORS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [1:0]    req_type,
  input  logic [FW-1:0] req_floor,
  input  logic [FW-1:0] cur_floor,
  input  logic          car_moving,
  input  logic          door_open,
  output logic          target_valid,
  output logic [FW-1:0] target_floor,
  output logic [1:0]    dir,
  output logic          stop_here,
  output logic [CW-1:0] pending_cnt,
  output logic          req_dup,
  output logic          req_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [N_FLOORS-1:0] cab_q, cab_d;
  logic [N_FLOORS-1:0] hup_q, hup_d;
  logic [N_FLOORS-1:0] hdn_q, hdn_d;
  logic [FW-1:0] tgt_q, tgt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tv_q, tv_d;
  logic stop_q, stop_d;
  logic dup_q, dup_d;
  logic err_q, err_d;

  logic [N_FLOORS-1:0] pend, cur_oh, req_oh;
  logic any_above, any_below;
  logic [FW-1:0] up_near, dn_near, dist_up, dist_dn;
  logic ua_v, uh_v, dh_v, dl_v;
  logic [FW-1:0] ua, uh, dh, dl;
  logic [FW-1:0] idle_tgt, scan_tgt;

  // Scan helpers: nearest pending floors and per-direction candidates.
  always_comb begin
    pend      = cab_q | hup_q | hdn_q;
    cur_oh    = '0;
    req_oh    = '0;
    any_above = 1'b0;
    any_below = 1'b0;
    up_near   = '0;
    dn_near   = '0;
    ua_v = 1'b0; ua = '0;
    uh_v = 1'b0; uh = '0;
    dh_v = 1'b0; dh = '0;
    dl_v = 1'b0; dl = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      cur_oh[f] = (int'(cur_floor) == f);
      req_oh[f] = (int'(req_floor) == f);
    end
    for (int f = N_FLOORS-1; f >= 0; f--) begin
      if (f > int'(cur_floor) && pend[f]) begin
        any_above = 1'b1;
        up_near   = FW'(f);
      end
      if (f > int'(cur_floor) && (cab_q[f] | hup_q[f])) begin
        ua_v = 1'b1;
        ua   = FW'(f);
      end
      if (f < int'(cur_floor) && hup_q[f]) begin
        dl_v = 1'b1;
        dl   = FW'(f);
      end
    end
    for (int f = 0; f < N_FLOORS; f++) begin
      if (f < int'(cur_floor) && pend[f]) begin
        any_below = 1'b1;
        dn_near   = FW'(f);
      end
      if (f < int'(cur_floor) && (cab_q[f] | hdn_q[f])) begin
        dh_v = 1'b1;
        dh   = FW'(f);
      end
      if (f > int'(cur_floor) && hdn_q[f]) begin
        uh_v = 1'b1;
        uh   = FW'(f);
      end
    end
    dist_up = up_near - cur_floor;
    dist_dn = cur_floor - dn_near;
  end

  always_comb begin
    idle_tgt = dn_near;
    if (|(pend & cur_oh))
      idle_tgt = cur_floor;
    else if (any_above && any_below)
      idle_tgt = (dist_up < dist_dn) ? up_near : dn_near;
    else if (any_above)
      idle_tgt = up_near;
    scan_tgt = idle_tgt;
    unique case (state_q)
      ST_UP:   scan_tgt = ua_v ? ua : (uh_v ? uh : idle_tgt);
      ST_DOWN: scan_tgt = dh_v ? dh : (dl_v ? dl : idle_tgt);
      default: scan_tgt = idle_tgt;
    endcase
  end

  logic svc, hit, already, bad;
  logic [N_FLOORS-1:0] clr_cab, clr_hup, clr_hdn, sel_q, sel_clr;

  // Door service clear first; a same-cycle call on a cleared bit is dropped.
  always_comb begin
    svc     = door_open & ~car_moving;
    clr_cab = svc ? cur_oh : '0;
    clr_hup = '0;
    clr_hdn = '0;
    if (svc) begin
      if (state_q != ST_DOWN || !any_below) clr_hup = cur_oh;
      if (state_q != ST_UP || !any_above)   clr_hdn = cur_oh;
    end
    bad = (req_type == 2'd3)
        || (int'(req_floor) >= N_FLOORS)
        || (req_type == 2'd1 && int'(req_floor) == N_FLOORS-1)
        || (req_type == 2'd2 && req_floor == '0);
    sel_q   = '0;
    sel_clr = '0;
    unique case (1'b1)
      req_type == 2'd0: begin sel_q = cab_q; sel_clr = clr_cab; end
      req_type == 2'd1: begin sel_q = hup_q; sel_clr = clr_hup; end
      req_type == 2'd2: begin sel_q = hdn_q; sel_clr = clr_hdn; end
      default: begin sel_q = '0; sel_clr = '0; end
    endcase
    hit     = |(req_oh & sel_clr);
    already = |(req_oh & sel_q);
    cab_d = cab_q & ~clr_cab;
    hup_d = hup_q & ~clr_hup;
    hdn_d = hdn_q & ~clr_hdn;
    dup_d = 1'b0;
    err_d = 1'b0;
    if (req_valid) begin
      if (bad) begin
        err_d = 1'b1;
      end else if (!hit) begin
        if (already) begin
`ifdef CABIN_CANCEL_EN
          if (req_type == 2'd0) cab_d = cab_d & ~req_oh;
          else dup_d = 1'b1;
`else
          dup_d = 1'b1;
`endif
        end else begin
          unique case (1'b1)
            req_type == 2'd0: cab_d = cab_d | req_oh;
            req_type == 2'd1: hup_d = hup_d | req_oh;
            default:          hdn_d = hdn_d | req_oh;
          endcase
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (!car_moving && !door_open) begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_above && any_below)
            state_d = (dist_up <= dist_dn) ? ST_UP : ST_DOWN;
          else if (any_above) state_d = ST_UP;
          else if (any_below) state_d = ST_DOWN;
        end
        ST_UP:
          state_d = any_above ? ST_UP : (any_below ? ST_DOWN : ST_IDLE);
        ST_DOWN:
          state_d = any_below ? ST_DOWN : (any_above ? ST_UP : ST_IDLE);
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int f = 0; f < N_FLOORS; f++)
      cnt_d = cnt_d + CW'(cab_q[f]) + CW'(hup_q[f]) + CW'(hdn_q[f]);
    tv_d  = (cnt_d != '0);
    tgt_d = tv_d ? scan_tgt : tgt_q;
    stop_d = |(cur_oh & (cab_q
      | ((state_q != ST_DOWN) ? hup_q : '0)
      | ((state_q != ST_UP)   ? hdn_q : '0)
      | ((state_q == ST_UP   && !any_above) ? hdn_q : '0)
      | ((state_q == ST_DOWN && !any_below) ? hup_q : '0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cab_q   <= '0;
      hup_q   <= '0;
      hdn_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      tv_q    <= 1'b0;
      stop_q  <= 1'b0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cab_q   <= cab_d;
      hup_q   <= hup_d;
      hdn_q   <= hdn_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      tv_q    <= tv_d;
      stop_q  <= stop_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
    end
  end

  assign target_valid = tv_q;
  assign target_floor = tgt_q;
  assign dir          = state_q;
  assign stop_here    = stop_q;
  assign pending_cnt  = cnt_q;
  assign req_dup      = dup_q;
  assign req_err      = err_q;

endmodule

// File: tb/tb_gestor_solicitudes_n.sv
// Bench for gestor_solicitudes_n (N_FLOORS=7): directed scenarios plus
// random traffic against a floor-array reference model.
module tb_gestor_solicitudes_n;
  localparam int N  = 7;
  localparam int FW = $clog2(N);
  localparam int CW = $clog2(3*N+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [1:0] req_type = '0;
  logic [FW-1:0] req_floor = '0;
  logic [FW-1:0] cur_floor = '0;
  logic car_moving = 1'b0;
  logic door_open = 1'b0;
  logic target_valid;
  logic [FW-1:0] target_floor;
  logic [1:0] dir;
  logic stop_here;
  logic [CW-1:0] pending_cnt;
  logic req_dup;
  logic req_err;

  gestor_solicitudes_n #(.N_FLOORS(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_type(req_type),
    .req_floor(req_floor), .cur_floor(cur_floor),
    .car_moving(car_moving), .door_open(door_open),
    .target_valid(target_valid), .target_floor(target_floor),
    .dir(dir), .stop_here(stop_here),
    .pending_cnt(pending_cnt),
    .req_dup(req_dup), .req_err(req_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit mcab[N];
  bit mhup[N];
  bit mhdn[N];
  int mst = 0;
  int exp_tf = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic bit pend(int f);
    return mcab[f] | mhup[f] | mhdn[f];
  endfunction

  function automatic int near_up(int c);
    for (int f = c + 1; f < N; f++) if (pend(f)) return f;
    return -1;
  endfunction

  function automatic int near_dn(int c);
    for (int f = c - 1; f >= 0; f--) if (pend(f)) return f;
    return -1;
  endfunction

  function automatic int idle_target(int c);
    int u, d;
    u = near_up(c);
    d = near_dn(c);
    if (pend(c)) return c;
    if (u >= 0 && d >= 0) return (u - c < c - d) ? u : d;
    if (u >= 0) return u;
    return d;
  endfunction

  function automatic int model_target(int c);
    if (mst == 1) begin
      for (int f = c + 1; f < N; f++) if (mcab[f] | mhup[f]) return f;
      for (int f = N - 1; f > c; f--) if (mhdn[f]) return f;
    end else if (mst == 2) begin
      for (int f = c - 1; f >= 0; f--) if (mcab[f] | mhdn[f]) return f;
      for (int f = 0; f < c; f++) if (mhup[f]) return f;
    end
    return idle_target(c);
  endfunction

  task automatic step(input bit v, input int t, input int f,
                      input int c, input bit mv, input bit dr);
    int cnt, ns;
    bit up, dn, svc, chup, chdn, err, dup, hit, stp;
    @(negedge clk);
    req_valid  = v;
    req_type   = 2'(t);
    req_floor  = FW'(f);
    cur_floor  = FW'(c);
    car_moving = mv;
    door_open  = dr;
    cnt = 0;
    for (int i = 0; i < N; i++)
      cnt += int'(mcab[i]) + int'(mhup[i]) + int'(mhdn[i]);
    up = near_up(c) >= 0;
    dn = near_dn(c) >= 0;
    if (cnt != 0) exp_tf = model_target(c);
    stp = mcab[c]
        | (mst == 1 && (mhup[c] || (!up && mhdn[c])))
        | (mst == 2 && (mhdn[c] || (!dn && mhup[c])))
        | (mst == 0 && (mhup[c] || mhdn[c]));
    ns = mst;
    if (!mv && !dr) begin
      case (mst)
        0: if (up && dn) ns = (near_up(c) - c <= c - near_dn(c)) ? 1 : 2;
           else if (up) ns = 1;
           else if (dn) ns = 2;
        1: ns = up ? 1 : (dn ? 2 : 0);
        default: ns = dn ? 2 : (up ? 1 : 0);
      endcase
    end
    svc  = dr && !mv;
    chup = svc && (mst != 2 || !dn);
    chdn = svc && (mst != 1 || !up);
    err = v && (t == 3 || f >= N || (t == 1 && f == N - 1) || (t == 2 && f == 0));
    dup = 0;
    hit = (f == c) && ((t == 0 && svc) || (t == 1 && chup) || (t == 2 && chdn));
    if (svc)  mcab[c] = 0;
    if (chup) mhup[c] = 0;
    if (chdn) mhdn[c] = 0;
    if (v && !err && !hit) begin
      case (t)
        0: if (mcab[f]) begin
`ifdef CABIN_CANCEL_EN
             mcab[f] = 0;
`else
             dup = 1;
`endif
           end else mcab[f] = 1;
        1: if (mhup[f]) dup = 1; else mhup[f] = 1;
        default: if (mhdn[f]) dup = 1; else mhdn[f] = 1;
      endcase
    end
    mst = ns;
    @(posedge clk);
    #1;
    chk("dir", int'(dir), ns);
    chk("pending_cnt", int'(pending_cnt), cnt);
    chk("target_valid", int'(target_valid), int'(cnt != 0));
    chk("target_floor", int'(target_floor), exp_tf);
    chk("stop_here", int'(stop_here), int'(stp));
    chk("req_dup", int'(req_dup), int'(dup));
    chk("req_err", int'(req_err), int'(err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_dir", int'(dir), 0);
    chk("rst_cnt", int'(pending_cnt), 0);
    chk("rst_tv", int'(target_valid), 0);
    chk("rst_tf", int'(target_floor), 0);
    chk("rst_stop", int'(stop_here), 0);
    chk("rst_flags", int'({req_dup, req_err}), 0);
    for (int i = 0; i < N; i++) begin
      mcab[i] = 0; mhup[i] = 0; mhdn[i] = 0;
    end
    mst = 0;
    exp_tf = 0;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int c;
    bit mv;
    do_reset();

    // Reset mid-run with cab floors 1 and 3 pending
    step(1, 0, 1, 0, 1, 0);
    step(1, 0, 3, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("pre_rst_cnt", int'(pending_cnt), 2);
    do_reset();

    // Cabin 2 then hall-down 3 from ground
    step(1, 0, 2, 0, 0, 0);
    step(1, 2, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("s2_dir", int'(dir), 1);
    chk("s2_tf", int'(target_floor), 2);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 2, 1, 0);
    step(0, 0, 0, 2, 0, 1);
    step(0, 0, 0, 2, 0, 1);
    chk("s2_tf_next", int'(target_floor), 3);
    do_reset();

    // Illegal requests
    step(1, 1, N - 1, 0, 0, 0);
    chk("s3_err_top", int'(req_err), 1);
    step(1, 2, 0, 0, 0, 0);
    chk("s3_err_gnd", int'(req_err), 1);
    step(1, 0, 7, 0, 0, 0);
    chk("s3_err_range", int'(req_err), 1);
    step(1, 3, 2, 0, 0, 0);
    chk("s3_cnt", int'(pending_cnt), 0);

    // Duplicate cabin call
    step(1, 0, 1, 0, 1, 0);
    step(1, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
`ifdef CABIN_CANCEL_EN
    chk("s4_cnt", int'(pending_cnt), 0);
    chk("s4_tv", int'(target_valid), 0);
`else
    chk("s4_cnt", int'(pending_cnt), 1);
`endif
    do_reset();

    // Reversal pickup at floor 1 going up
    step(1, 1, 1, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("s5_cnt", int'(pending_cnt), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("s5_dir", int'(dir), 0);
    do_reset();

    // Equidistant calls from floor 4 resolve upward
    step(1, 0, 2, 4, 0, 1);
    step(1, 0, 6, 4, 0, 1);
    step(0, 0, 0, 4, 0, 0);
    chk("s6_tie_dir", int'(dir), 1);
    do_reset();
    step(1, 0, 3, 4, 0, 1);
    step(1, 0, 6, 4, 0, 1);
    step(0, 0, 0, 4, 0, 0);
    step(0, 0, 0, 4, 0, 0);
    chk("s6_dir", int'(dir), 2);
    chk("s6_tf", int'(target_floor), 3);
    do_reset();

    // Random traffic
    c = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(9) == 0) c = $urandom_range(N - 1);
      mv = ($urandom_range(4) == 0);
      step(bit'($urandom_range(1)), $urandom_range(3), $urandom_range(7),
           c, mv, !mv && ($urandom_range(3) == 0));
      if (k == 700) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
